// File: rtl/cells_frame_sequencer.sv
// Frame sequencer feeding the cell scan controller: buffers 16-bit cell frames in a FIFO,
// holds each frame for a programmable number of controller scans, then advances to the next.
module cells_frame_sequencer #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wr_valid,
  input  logic [15:0]   wr_data,
  output logic          wr_ready,
  input  logic          clear,
  input  logic          run,
  input  logic [7:0]    repeat_count,
  input  logic          update_done,
  output logic [15:0]   cells_state,
  output logic          system_enable_n,
  output logic          enable_sn,
  output logic          frame_done,
  output logic          busy,
  output logic          underrun,
  output logic [LW-1:0] level
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  state_t        state_r;
  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [7:0]    rep_r;
  logic          ud_q_r;
  logic          ud_rise_r;
  logic [15:0]   cells_state_r;
  logic          sys_en_n_r;
  logic          enable_sn_r;
  logic          frame_done_r;
  logic          underrun_r;

  logic          full_s;
  logic          empty_s;
  logic          wr_en_s;
  logic          pop_s;
  logic          advance_s;
  logic          rep_last_s;
  logic [7:0]    rep_target_s;
  logic [15:0]   head_s;

  assign full_s          = (level_r == FULL_LEVEL);
  assign empty_s         = (level_r == {LW{1'b0}});
  assign wr_ready        = ~full_s;
  assign wr_en_s         = wr_valid & ~full_s & ~clear;
  assign head_s          = mem_r[rd_ptr_r];
  assign level           = level_r;
  assign busy            = (state_r != ST_IDLE);
  assign cells_state     = cells_state_r;
  assign system_enable_n = sys_en_n_r;
  assign enable_sn       = enable_sn_r;
  assign frame_done      = frame_done_r;
  assign underrun        = underrun_r;

  // Frame-completion decision and FIFO pop request for the current cycle.
  always_comb begin
    rep_target_s = (repeat_count == 8'd0) ? 8'd1 : repeat_count;
    rep_last_s   = (({1'b0, rep_r} + 9'd1) >= {1'b0, rep_target_s});
    advance_s    = 1'b0;
    pop_s        = 1'b0;
    if (clear) begin
      advance_s = 1'b0;
      pop_s     = 1'b0;
    end else begin
      case (state_r)
        ST_PRIME: begin
          pop_s = ~empty_s;
        end
        ST_SCAN: begin
          if (run && ud_rise_r && rep_last_s) begin
            advance_s = 1'b1;
            pop_s     = ~empty_s;
          end else begin
            advance_s = 1'b0;
            pop_s     = 1'b0;
          end
        end
        default: begin
          advance_s = 1'b0;
          pop_s     = 1'b0;
        end
      endcase
    end
  end

  // Frame storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers and occupancy; a write and a pop in the same cycle cancel in the level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sequencer state machine with registered controller outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      rep_r         <= 8'd0;
      ud_q_r        <= 1'b0;
      ud_rise_r     <= 1'b0;
      cells_state_r <= 16'h0000;
      sys_en_n_r    <= 1'b1;
      enable_sn_r   <= 1'b0;
      frame_done_r  <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      ud_q_r <= update_done;
      if (clear) begin
        state_r      <= ST_IDLE;
        rep_r        <= 8'd0;
        ud_rise_r    <= 1'b0;
        sys_en_n_r   <= 1'b1;
        enable_sn_r  <= 1'b0;
        frame_done_r <= 1'b0;
        underrun_r   <= 1'b0;
      end else begin
        // A rise only counts if the controller was actually scanning when it arrived.
        ud_rise_r    <= update_done & ~ud_q_r & (state_r == ST_SCAN);
        sys_en_n_r   <= (state_r != ST_SCAN);
        enable_sn_r  <= (state_r == ST_PRIME);
        frame_done_r <= advance_s;
        if (pop_s) begin
          cells_state_r <= head_s;
        end
        case (state_r)
          ST_IDLE: begin
            rep_r <= 8'd0;
            if (run && !empty_s) begin
              state_r <= ST_PRIME;
            end
          end
          ST_PRIME: begin
            rep_r   <= 8'd0;
            state_r <= ST_SCAN;
          end
          ST_SCAN: begin
            if (!run) begin
              state_r <= ST_IDLE;
            end else if (ud_rise_r) begin
              if (!rep_last_s) begin
                rep_r <= rep_r + 8'd1;
              end else if (!empty_s) begin
                rep_r <= 8'd0;
              end else begin
                underrun_r <= 1'b1;
                state_r    <= ST_IDLE;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cells_frame_sequencer.sv
// Self-checking bench for cells_frame_sequencer: directed scenarios, a vector table and
// randomized traffic compared each cycle against a queue-based reference model.
module tb_cells_frame_sequencer;

  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          wr_valid;
  logic [15:0]   wr_data;
  logic          wr_ready;
  logic          clear;
  logic          run;
  logic [7:0]    repeat_count;
  logic          update_done;
  logic [15:0]   cells_state;
  logic          system_enable_n;
  logic          enable_sn;
  logic          frame_done;
  logic          busy;
  logic          underrun;
  logic [LW-1:0] level;

  always #5 clock = ~clock;

  cells_frame_sequencer #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .clear(clear), .run(run), .repeat_count(repeat_count),
    .update_done(update_done), .cells_state(cells_state),
    .system_enable_n(system_enable_n), .enable_sn(enable_sn), .frame_done(frame_done),
    .busy(busy), .underrun(underrun), .level(level)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: frame queue plus a few flags describing where the sequence stands.
  logic [15:0] m_q[$];
  logic [15:0] m_cur;
  bit          m_starting, m_running, m_pending, m_prev_ud;
  bit          m_underrun, m_en, m_se_n, m_fd;
  int          m_scans;

  typedef struct {
    logic        wr_valid;
    logic [15:0] wr_data;
    int          exp_level;
    logic        exp_ready;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_cur      = 16'h0000;
    m_starting = 1'b0;
    m_running  = 1'b0;
    m_pending  = 1'b0;
    m_prev_ud  = 1'b0;
    m_underrun = 1'b0;
    m_en       = 1'b0;
    m_se_n     = 1'b1;
    m_fd       = 1'b0;
    m_scans    = 0;
  endfunction

  // Applies one clock edge's worth of the sequencing rules to the model.
  function automatic void model_step();
    bit was_running;
    bit rise;
    bit can_write;
    int target;
    was_running = m_running;
    rise        = update_done && !m_prev_ud;
    can_write   = (m_q.size() < DEPTH);
    target      = (repeat_count == 8'd0) ? 1 : int'(repeat_count);
    m_prev_ud   = update_done;
    if (clear) begin
      m_q.delete();
      m_underrun = 1'b0;
      m_starting = 1'b0;
      m_running  = 1'b0;
      m_pending  = 1'b0;
      m_en       = 1'b0;
      m_se_n     = 1'b1;
      m_fd       = 1'b0;
      return;
    end
    m_en   = m_starting;
    m_se_n = !m_running;
    m_fd   = 1'b0;
    if (m_starting) begin
      m_cur      = m_q.pop_front();
      m_starting = 1'b0;
      m_running  = 1'b1;
      m_scans    = 0;
    end else if (m_running) begin
      if (!run) begin
        m_running = 1'b0;
      end else if (m_pending) begin
        if (m_scans + 1 < target) begin
          m_scans++;
        end else begin
          m_fd = 1'b1;
          if (m_q.size() > 0) begin
            m_cur   = m_q.pop_front();
            m_scans = 0;
          end else begin
            m_underrun = 1'b1;
            m_running  = 1'b0;
          end
        end
      end
    end else if (run && m_q.size() > 0) begin
      m_starting = 1'b1;
    end
    m_pending = rise && was_running;
    if (wr_valid && can_write) m_q.push_back(wr_data);
  endfunction

  task automatic compare_model();
    check("cells_state", 32'(cells_state), 32'(m_cur));
    check("system_enable_n", 32'(system_enable_n), 32'(m_se_n));
    check("enable_sn", 32'(enable_sn), 32'(m_en));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("underrun", 32'(underrun), 32'(m_underrun));
    check("level", 32'(level), 32'(m_q.size()));
    check("wr_ready", 32'(wr_ready), 32'(m_q.size() < DEPTH));
    check("busy", 32'(busy), 32'(m_running || m_starting));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    compare_model();
  endtask

  task automatic write_frame(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    vec_t        vecs[9];
    int          fd_cnt;
    int          en_cnt;
    int          wcount;
    int          ud_left;
    bit          ud_hi;
    logic [15:0] got[$];
    logic [15:0] prev;
    logic [15:0] exp_drain[8];

    for (int i = 0; i < 9; i++) begin
      vecs[i].wr_valid  = 1'b1;
      vecs[i].wr_data   = 16'h0100 + 16'(i);
      vecs[i].exp_level = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      vecs[i].exp_ready = (i + 1 < DEPTH);
    end
    exp_drain = '{16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h01FF, 16'h01FF};

    // Reset with run high and an empty FIFO: nothing may start.
    reset_n = 1'b0; wr_valid = 1'b0; wr_data = 16'h0000; clear = 1'b0;
    run = 1'b1; repeat_count = 8'd1; update_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) tick();
    check("rst_se_n", 32'(system_enable_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_cells", 32'(cells_state), 32'd0);

    // Three frames, two scans each, update_done pulsed every 40 cycles.
    run = 1'b0;
    write_frame(16'h0001); write_frame(16'h0200); write_frame(16'h03FF);
    repeat_count = 8'd2;
    run = 1'b1;
    tick();
    tick();
    check("start_en", 32'(enable_sn), 32'd1);
    check("start_cells", 32'(cells_state), 32'h0001);
    tick();
    check("start_se_n", 32'(system_enable_n), 32'd0);
    check("start_en_end", 32'(enable_sn), 32'd0);
    fd_cnt = 0; en_cnt = 0; got.delete();
    for (int c = 0; c < 300; c++) begin
      update_done = (c % 40 == 20);
      tick();
      if (enable_sn) en_cnt++;
      if (frame_done) begin
        fd_cnt++;
        got.push_back(cells_state);
      end
    end
    update_done = 1'b0;
    check("seq_fd_count", 32'(fd_cnt), 32'd3);
    check("seq_extra_en", 32'(en_cnt), 32'd0);
    if (got.size() == 3) begin
      check("seq_frame1", 32'(got[0]), 32'h0200);
      check("seq_frame2", 32'(got[1]), 32'h03FF);
      check("seq_frame3", 32'(got[2]), 32'h03FF);
    end else begin
      check("seq_frames_seen", 32'(got.size()), 32'd3);
    end
    check("seq_end_busy", 32'(busy), 32'd0);
    check("seq_end_underrun", 32'(underrun), 32'd1);
    check("seq_end_cells", 32'(cells_state), 32'h03FF);

    // repeat_count 0 with update_done held high: one advance per rise.
    run = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    write_frame(16'h00A1); write_frame(16'h00A2); write_frame(16'h00A3);
    repeat_count = 8'd0;
    run = 1'b1;
    repeat (3) tick();
    fd_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      update_done = ((c % 20) < 10);
      tick();
      if (frame_done) fd_cnt++;
      if (c % 20 == 19) check("hold_once", 32'(fd_cnt), 32'(c / 20 + 1));
    end
    update_done = 1'b0;
    check("hold_underrun", 32'(underrun), 32'd1);

    // clear colliding with a write and an update_done rise while scanning.
    run = 1'b0;
    write_frame(16'h00D1); write_frame(16'h00D2);
    run = 1'b1;
    repeat (3) tick();
    check("clr_pre_busy", 32'(busy), 32'd1);
    check("clr_pre_underrun", 32'(underrun), 32'd1);
    clear = 1'b1; wr_valid = 1'b1; wr_data = 16'hBEEF; update_done = 1'b1;
    tick();
    clear = 1'b0; wr_valid = 1'b0; update_done = 1'b0;
    check("clr_level", 32'(level), 32'd0);
    check("clr_underrun", 32'(underrun), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    tick();
    check("clr_level_after", 32'(level), 32'd0);
    check("clr_se_n_after", 32'(system_enable_n), 32'd1);

    // run dropped mid-frame, then re-asserted.
    run = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    write_frame(16'h00C1); write_frame(16'h00C2); write_frame(16'h00C3);
    repeat_count = 8'd3;
    run = 1'b1;
    repeat (3) tick();
    update_done = 1'b1; tick(); update_done = 1'b0;
    tick(); tick();
    run = 1'b0;
    tick();
    check("stop_fd_k", 32'(frame_done), 32'd0);
    tick();
    check("stop_se_n", 32'(system_enable_n), 32'd1);
    check("stop_fd", 32'(frame_done), 32'd0);
    check("stop_level", 32'(level), 32'd2);
    check("stop_busy", 32'(busy), 32'd0);
    run = 1'b1;
    tick(); tick();
    check("restart_en", 32'(enable_sn), 32'd1);
    check("restart_cells", 32'(cells_state), 32'h00C2);
    check("restart_level", 32'(level), 32'd1);

    // Fill table: eight writes fill the FIFO, the ninth is dropped.
    run = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_valid = vecs[i].wr_valid;
      wr_data  = vecs[i].wr_data;
      tick();
      check("fill_level", 32'(level), 32'(vecs[i].exp_level));
      check("fill_ready", 32'(wr_ready), 32'(vecs[i].exp_ready));
    end
    wr_valid = 1'b0;

    // Pop and write in the same cycle at full-minus-one.
    repeat_count = 8'd1;
    run = 1'b1;
    repeat (3) tick();
    check("pw_pre_level", 32'(level), 32'd7);
    update_done = 1'b1; tick(); update_done = 1'b0;
    wr_valid = 1'b1; wr_data = 16'h01FF;
    tick();
    wr_valid = 1'b0;
    check("pw_level", 32'(level), 32'd7);
    check("pw_fd", 32'(frame_done), 32'd1);
    check("pw_cells", 32'(cells_state), 32'h0101);
    got.delete();
    for (int c = 0; c < 60; c++) begin
      update_done = (c % 4 == 0);
      tick();
      if (frame_done) got.push_back(cells_state);
    end
    update_done = 1'b0;
    check("drain_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) check("drain_data", 32'(got[i]), 32'(exp_drain[i]));
    end

    // Twenty frames streamed through so the pointers wrap repeatedly.
    run = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    run = 1'b1;
    wcount = 0; got.delete(); prev = cells_state;
    for (int c = 0; c < 400; c++) begin
      wr_valid    = (wcount < 20) && wr_ready;
      wr_data     = 16'h0500 + 16'(wcount);
      update_done = (c % 6 == 3);
      tick();
      if (wr_valid) wcount++;
      if (cells_state != prev) begin
        got.push_back(cells_state);
        prev = cells_state;
      end
    end
    wr_valid = 1'b0; update_done = 1'b0;
    check("wrap_count", 32'(got.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (i < got.size()) check("wrap_data", 32'(got[i]), 32'h0500 + 32'(i));
    end

    // Randomized traffic against the model.
    clear = 1'b1; tick(); clear = 1'b0;
    ud_left = 0; ud_hi = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_data  = 16'($urandom);
      if ($urandom_range(0, 49) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) repeat_count = 8'($urandom_range(0, 3));
      clear = ($urandom_range(0, 199) == 0);
      if (ud_left == 0) begin
        ud_hi   = ~ud_hi;
        ud_left = ud_hi ? $urandom_range(1, 5) : $urandom_range(3, 15);
      end
      ud_left--;
      update_done = ud_hi;
      tick();
    end
    clear = 1'b0; wr_valid = 1'b0; update_done = 1'b0;

    // Asynchronous reset in the middle of a cycle.
    run = 1'b1;
    write_frame(16'h0777);
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_cells", 32'(cells_state), 32'd0);
    check("arst_se_n", 32'(system_enable_n), 32'd1);
    check("arst_en", 32'(enable_sn), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
